// File: rtl/led_matrix_scan.sv
// led_matrix_scan: 4x4 multiplexed LED-matrix scan driver with 4-bit PWM per pixel.
// Rows are scanned one at a time. Each row gets BLANK_TICKS dark ticks, then 15 ON ticks
// in which column c is lit while the tick index is below that pixel's level.
// A double-buffered frame store lets upstream logic fill the back buffer while the
// front buffer is displayed. Buffer roles swap only at a frame boundary.
module led_matrix_scan #(
    parameter int PRESCALE    = 750,
    parameter int BLANK_TICKS = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       swap_req,
    output logic [3:0] aled,
    output logic [3:0] kled_en,
    output logic       frame_start,
    output logic       swap_done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int TW = ($clog2(BLANK_TICKS + 1) > 4) ? $clog2(BLANK_TICKS + 1) : 4;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);
    localparam logic [TW-1:0] BLANK_LAST    = TW'(BLANK_TICKS - 1);
    localparam logic [TW-1:0] ON_LAST       = TW'(14);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [TW-1:0] r_tick;        // blank tick count in BLANK, PWM slot t in ON
    logic [1:0]    r_row;
    logic          r_front_b;     // 0: buffer A is displayed, 1: buffer B is displayed
    logic          r_pending;     // swap requested, waiting for the frame boundary
    logic          r_bound;       // first BLANK cycle of row 0 after a frame boundary
    logic          r_bound_swap;  // same cycle, and the boundary exchanged the buffers
    logic [3:0]    r_buf_a [16];
    logic [3:0]    r_buf_b [16];

    logic          w_tick_en;
    logic          w_frame_end;
    logic          w_do_swap;
    logic [3:0]    w_px;
    logic [3:0]    w_lit;

    assign w_tick_en   = (r_presc == PRESCALE_LAST);
    assign w_frame_end = w_tick_en && (r_state == ST_ON) && (r_tick == ON_LAST) && (r_row == 2'd3);
    // A request arriving on the boundary cycle itself still takes effect at this boundary.
    assign w_do_swap   = w_frame_end && (r_pending || swap_req);

    // Prescaler: free-running divider, one tick_en per PRESCALE clocks.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_presc <= '0;
        end else if (w_tick_en) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Scan FSM: row/tick sequencing, swap bookkeeping and frame-boundary flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_BLANK;
            r_tick       <= '0;
            r_row        <= 2'd0;
            r_front_b    <= 1'b0;
            r_pending    <= 1'b0;
            r_bound      <= 1'b0;
            r_bound_swap <= 1'b0;
        end else begin
            r_bound      <= w_frame_end;
            r_bound_swap <= w_do_swap;

            if (w_do_swap) begin
                r_front_b <= ~r_front_b;
                r_pending <= 1'b0;
            end else if (swap_req) begin
                r_pending <= 1'b1;
            end

            if (w_tick_en) begin
                if (r_state == ST_BLANK) begin
                    if (r_tick == BLANK_LAST) begin
                        r_state <= ST_ON;
                        r_tick  <= '0;
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end else begin
                    if (r_tick == ON_LAST) begin
                        r_state <= ST_BLANK;
                        r_tick  <= '0;
                        r_row   <= r_row + 2'd1;
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
            end
        end
    end

    // Frame store: writes always target whichever buffer is currently the back buffer.
    // NOTE: the store is reset because a reset must leave every pixel dark; 128 flops is acceptable here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 16; i++) begin
                r_buf_a[i] <= '0;
                r_buf_b[i] <= '0;
            end
        end else if (wr_en) begin
            if (r_front_b) begin
                r_buf_a[wr_addr] <= wr_data;
            end else begin
                r_buf_b[wr_addr] <= wr_data;
            end
        end
    end

    // PWM compare: column c of the current row is lit while t < its brightness level.
    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        w_px  = '0;
        w_lit = '0;
        for (int c = 0; c < 4; c++) begin
            w_px     = r_front_b ? r_buf_b[{r_row, 2'(c)}] : r_buf_a[{r_row, 2'(c)}];
            w_lit[c] = (r_tick < TW'(w_px));
        end
    end

    // Output register: pins change one clock after the state they reflect, glitch-free.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aled        <= '0;
            kled_en     <= '0;
            frame_start <= 1'b0;
            swap_done   <= 1'b0;
        end else begin
            if (r_state == ST_ON) begin
                aled    <= 4'b0001 << r_row;
                kled_en <= w_lit;
            end else begin
                aled    <= '0;
                kled_en <= '0;
            end
            frame_start <= r_bound;
            swap_done   <= r_bound_swap;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: self-checking bench for led_matrix_scan.
// A scan-position model derived from the edge count since reset release predicts every
// output on every cycle of the fast instance (PRESCALE=1). A second instance with
// PRESCALE=750 covers the asynchronous mid-row reset and the slow restart timing.
`timescale 1ns/1ps
module tb_led_matrix_scan;

    localparam int P     = 1;
    localparam int B     = 1;
    localparam int R     = B + 15;       // ticks per row
    localparam int FT    = 4 * R;        // ticks per frame
    localparam int PS    = 750;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Fast instance signals
    logic       resetn, wr_en, swap_req;
    logic [3:0] wr_addr, wr_data;
    logic [3:0] aled, kled_en;
    logic       frame_start, swap_done;

    // Slow instance signals
    logic       resetn_s;
    logic       s_wr_en, s_swap_req;
    logic [3:0] s_wr_addr, s_wr_data;
    logic [3:0] s_aled, s_kled;
    logic       s_fs, s_sd;

    int n_checks = 0;
    int n_fail   = 0;

    led_matrix_scan #(.PRESCALE(P), .BLANK_TICKS(B)) dut (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap_req(swap_req), .aled(aled), .kled_en(kled_en),
        .frame_start(frame_start), .swap_done(swap_done)
    );

    led_matrix_scan #(.PRESCALE(PS), .BLANK_TICKS(1)) dut_s (
        .clk(clk), .resetn(resetn_s), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .swap_req(s_swap_req), .aled(s_aled), .kled_en(s_kled),
        .frame_start(s_fs), .swap_done(s_sd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the fast instance ----------------
    int         mk;                 // clock edges since reset release
    logic [3:0] mbuf [2][16];
    int         mfront;
    bit         mpend, mlast_swap;
    logic [3:0] e_aled, e_kled;
    logic       e_fs, e_sd;

    task automatic model_reset();
        mk = 0; mfront = 0; mpend = 0; mlast_swap = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 16; i++) mbuf[b][i] = 4'd0;
        e_aled = '0; e_kled = '0; e_fs = 1'b0; e_sd = 1'b0;
    endtask

    task automatic model_edge();
        int pos, m, ph, row;
        mk++;
        // Outputs after edge mk show the scan position reached after edge mk-1.
        pos = mk - 1;
        m   = pos / P;
        ph  = m % R;
        row = (m / R) % 4;
        e_aled = '0;
        e_kled = '0;
        if (ph >= B) begin
            e_aled = 4'(1 << row);
            for (int c = 0; c < 4; c++)
                e_kled[c] = ((ph - B) < int'(mbuf[mfront][row * 4 + c]));
        end
        e_fs = (m > 0) && (pos % P == 0) && (m % FT == 0);
        e_sd = e_fs && mlast_swap;
        // Apply this edge: write lands in the pre-swap back buffer, then the boundary swap.
        if (wr_en) mbuf[1 - mfront][wr_addr] = wr_data;
        if (swap_req) mpend = 1;
        mlast_swap = 0;
        if ((mk % P == 0) && ((mk / P) % FT == 0) && mpend) begin
            mfront     = 1 - mfront;
            mpend      = 0;
            mlast_swap = 1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) model_reset();
            else         model_edge();
        end
    end

    // Cycle-by-cycle comparison on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("aled",        aled,        e_aled);
            check("kled_en",     kled_en,     e_kled);
            check("frame_start", frame_start, e_fs);
            check("swap_done",   swap_done,   e_sd);
        end
    end

    // ---------------- helpers ----------------
    int lit [4][4];
    int on_cnt [4];
    int sd_cnt, fs_cnt, kled_any;

    task automatic scan(input int n);
        for (int r = 0; r < 4; r++) begin
            on_cnt[r] = 0;
            for (int c = 0; c < 4; c++) lit[r][c] = 0;
        end
        sd_cnt = 0; fs_cnt = 0; kled_any = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int r = 0; r < 4; r++) begin
                if (aled[r]) on_cnt[r]++;
                for (int c = 0; c < 4; c++)
                    if (aled[r] && kled_en[c]) lit[r][c]++;
            end
            if (swap_done)      sd_cnt++;
            if (frame_start)    fs_cnt++;
            if (kled_en != '0)  kled_any++;
        end
    endtask

    task automatic wait_fs(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start && k < 200);
        check(name, frame_start, 1'b1);
    endtask

    task automatic write_px(input logic [3:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    task automatic wait_mk_mod(input int target);
        int k;
        k = 0;
        while ((mk % FT != target) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("align_timeout", k < 200, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k, tot0, tot3;
        resetn = 1'b0; wr_en = 1'b0; swap_req = 1'b0; wr_addr = '0; wr_data = '0;
        resetn_s = 1'b0; s_wr_en = 1'b0; s_swap_req = 1'b0; s_wr_addr = '0; s_wr_data = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // 1: reset release timing
        @(negedge clk);
        check("t1_blank_after_release", aled, 4'b0000);
        @(negedge clk);
        check("t1_row0_first_on", aled, 4'b0001);
        check("t1_row0_dark", kled_en, 4'b0000);
        k = 2;
        while (!frame_start && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t1_first_frame_start_edge", k, 65);
        check("t1_no_swap_done", swap_done, 1'b0);

        // 2: single pixel (row1,col1)=7 then swap
        write_px(4'h5, 4'd7);
        pulse_swap();
        wait_fs("t2_frame_start");
        check("t2_swap_done", swap_done, 1'b1);
        scan(FT);
        check("t2_row1_on_clks", on_cnt[1], 15);
        check("t2_px11_lit_clks", lit[1][1], 7);
        check("t2_px10_lit_clks", lit[1][0], 0);

        // 3: levels 15 and 0
        for (int r = 0; r < 4; r++) begin
            write_px(4'({r[1:0], 2'd0}), 4'd15);
            write_px(4'({r[1:0], 2'd3}), 4'd0);
            write_px(4'({r[1:0], 2'd1}), 4'($urandom_range(0, 15)));
        end
        pulse_swap();
        wait_fs("t3_frame_start");
        check("t3_swap_done", swap_done, 1'b1);
        scan(FT);
        tot0 = 0; tot3 = 0;
        for (int r = 0; r < 4; r++) begin
            tot0 += lit[r][0];
            tot3 += lit[r][3];
        end
        check("t3_col0_full_clks", tot0, 60);
        check("t3_col3_never_lit", tot3, 0);

        // 4: three requests in one frame merge into one swap
        pulse_swap();
        repeat (2) @(negedge clk);
        pulse_swap();
        repeat (3) @(negedge clk);
        pulse_swap();
        scan(2 * FT - 8);
        check("t4_one_swap_done", sd_cnt, 1);
        check("t4_two_frame_starts", fs_cnt, 2);

        // 5: write and swap on the boundary cycle
        wait_mk_mod(FT - 1);
        wr_en = 1'b1; wr_addr = 4'h0; wr_data = 4'd9; swap_req = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; swap_req = 1'b0;
        @(negedge clk);
        check("t5_frame_start", frame_start, 1'b1);
        check("t5_swap_done", swap_done, 1'b1);
        scan(FT);
        check("t5_px00_lit_clks", lit[0][0], 9);

        // Randomised writes and swap requests, checked by the model every cycle
        for (int i = 0; i < 6 * FT; i++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = 4'($urandom_range(0, 15));
            wr_data  = 4'($urandom_range(0, 15));
            swap_req = ($urandom_range(0, 31) == 0);
            @(negedge clk);
        end
        wr_en = 1'b0; swap_req = 1'b0;

        // Mid-row reset on the fast instance: buffers must come back dark
        wait_mk_mod(40);
        check("t6f_row2_on_before_reset", aled, 4'b0100);
        #2 resetn = 1'b0;
        #1;
        check("t6f_aled_async_clear", aled, 4'b0000);
        check("t6f_kled_async_clear", kled_en, 4'b0000);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        pulse_swap();
        scan(2 * FT + 8);
        check("t6f_all_dark_after_reset", kled_any, 0);
        check("t6f_swap_after_reset", sd_cnt, 1);

        // 6: slow instance, reset asserted during row 2 ON
        resetn_s = 1'b1;
        k = 0;
        while (s_aled != 4'b0100 && k < 30000) begin
            @(negedge clk);
            k++;
        end
        check("t6_reach_row2", s_aled, 4'b0100);
        repeat (100) @(negedge clk);
        check("t6_still_row2_on", s_aled, 4'b0100);
        #2 resetn_s = 1'b0;
        #1;
        check("t6_aled_async_clear", s_aled, 4'b0000);
        check("t6_kled_async_clear", s_kled, 4'b0000);
        repeat (2) @(negedge clk);
        resetn_s = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (s_aled == 4'b0000 && k < 2000);
        check("t6_restart_first_on_edge", k, PS + 1);
        check("t6_restart_row0", s_aled, 4'b0001);
        check("t6_restart_dark", s_kled, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
